mem_map_ctrl: RTL and testbench
===============================

MEM_MAP_CTRL -- requirements
Module: mem_map_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, data width.
- ADDR_W, 32, byte-independent word address width.
- NUM_REGIONS, 4, number of data regions.
- REGION_BASE, {32'd0, 32'd8900, 32'd8500, 32'd400}, packed NUM_REGIONS*ADDR_W base addresses (region 0 in the LSBs).
- REGION_SIZE, {32'd0, 32'd129200, 32'd300, 32'd8100}, packed sizes; a size of 0 disables the region.
- REGION_WS, {4'd0, 4'd1, 4'd0, 4'd0}, packed 4-bit wait states per region.
- REGION_RO, 4'b0011, read-only bitmask, bit i for region i.
- IMEM_SIZE, 399, instruction window size.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  data request.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  data address.
- req_wd  in  DATA_W  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rd  out  DATA_W  read data, valid with resp_valid.
- resp_err  out  1  access error, valid with resp_valid.
- reg_en  out  NUM_REGIONS  one-hot region enable.
- reg_we  out  1  region write strobe.
- reg_addr  out  ADDR_W  region-relative offset.
- reg_wd  out  DATA_W  region write data.
- reg_rd  in  NUM_REGIONS*DATA_W  packed region read data.
- pc  in  ADDR_W  fetch address.
- imem_addr  out  ADDR_W  instruction memory address.
- imem_rd  in  DATA_W  instruction memory data.
- instruction  out  DATA_W  registered instruction.

Function
REQ-003 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a clock edge where req_valid && req_ready.
REQ-005 On accept, the block SHALL register the decode result: the lowest-index region i with REGION_SIZE[i]!=0 and BASE[i] <= addr < BASE[i]+SIZE[i]; the offset addr-BASE[i]; req_wd; req_we.
REQ-006 If a region hits, the FSM SHALL move IDLE->ACCESS and load the wait counter with REGION_WS[i]. If no region hits, the FSM SHALL move IDLE->RESP.
REQ-007 In ACCESS, reg_en SHALL be one-hot for the selected region and reg_addr/reg_wd SHALL hold the registered values.
REQ-008 The counter SHALL decrement each cycle in ACCESS; when it is 0, the block SHALL capture reg_rd[i] and move ACCESS->RESP.
REQ-009 reg_we SHALL pulse exactly once, in the first ACCESS cycle, and only for a write to a region with REGION_RO[i]=0.
REQ-010 A write to a read-only region SHALL perform no reg_we pulse but still complete normally.
REQ-011 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL move RESP->IDLE.
REQ-012 Latency SHALL be: mapped access, WS+2 cycles from the accept edge to resp_valid; unmapped access, 1 cycle.
REQ-013 resp_rd SHALL be the captured data for a mapped read and 0 for writes and unmapped accesses.
REQ-014 resp_rd SHALL hold its value until the next response.
REQ-015 reg_en SHALL be 0 and reg_we SHALL be 0 outside ACCESS.
REQ-016 Boundary addresses SHALL decode as follows: BASE+SIZE-1 hits; BASE+SIZE misses; overlapping regions resolve by lowest index.
REQ-017 Offset arithmetic SHALL be ADDR_W bits, unsigned, with no wrap (a hit implies addr >= BASE).
REQ-018 The fetch port SHALL drive imem_addr=pc combinationally.
REQ-019 instruction SHALL be registered each cycle as imem_rd when pc < IMEM_SIZE, else 0 (1-cycle latency), independent of the data FSM.

Reset
REQ-020 On rst_n=0, asynchronously: state=IDLE, counter=0, resp_valid=0, resp_rd=0, resp_err=0, reg_en=0, reg_we=0, reg_addr=0, reg_wd=0, instruction=0.
REQ-021 Reset mid-transaction SHALL drop the transaction with no reg_we pulse and no response.
REQ-022 After release, req_ready SHALL be 1 on the first cycle.

Configuration
REQ-023 With MEM_MAP_CTRL_ACCESS_ERR_EN defined, resp_err SHALL be 1 with resp_valid for unmapped accesses and for writes to read-only regions.
REQ-024 Without MEM_MAP_CTRL_ACCESS_ERR_EN, resp_err SHALL be tied to 0 and the same accesses SHALL complete silently.

Verification
REQ-025 Read 400, reg_rd[0]=32'hA5 -> reg_en=4'b0001, reg_addr=0, resp_valid 2 cycles after accept, resp_rd=32'hA5.
REQ-026 Write 8900 with data 32'h1234 -> reg_en=4'b0100, reg_we pulse, reg_addr=0, resp_valid 3 cycles after accept (WS=1).
REQ-027 Read 8499 -> region 0, reg_addr=8099; read 8800 -> unmapped, resp_rd=0, resp_valid 1 cycle after accept, resp_err=1 with the macro defined.
REQ-028 Write 8500 -> no reg_we, resp_err=1 with the macro defined, 0 without it.
REQ-029 pc=5 then pc=400 -> instruction=imem_rd one cycle later, then 0.
REQ-030 rst_n low during an 8900 access in ACCESS -> no response, all outputs 0, req_ready=1 after release.

Source files
------------

// File: rtl/mem_map_ctrl.sv
// Region-decoding data access controller with per-region wait states, plus a registered instruction fetch port.
// Define MEM_MAP_CTRL_ACCESS_ERR_EN to report unmapped accesses and read-only writes on resp_err.
module mem_map_ctrl #(
  parameter int                             DATA_W      = 32,
  parameter int                             ADDR_W      = 32,
  parameter int                             NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE = {32'd0, 32'd8900, 32'd8500, 32'd400},
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_SIZE = {32'd0, 32'd129200, 32'd300, 32'd8100},
  parameter logic [NUM_REGIONS*4-1:0]       REGION_WS   = {4'd0, 4'd1, 4'd0, 4'd0},
  parameter logic [NUM_REGIONS-1:0]         REGION_RO   = 4'b0011,
  parameter logic [ADDR_W-1:0]              IMEM_SIZE   = 32'd399
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wd,
  output logic                          resp_valid,
  output logic [DATA_W-1:0]             resp_rd,
  output logic                          resp_err,
  output logic [NUM_REGIONS-1:0]        reg_en,
  output logic                          reg_we,
  output logic [ADDR_W-1:0]             reg_addr,
  output logic [DATA_W-1:0]             reg_wd,
  input  logic [NUM_REGIONS*DATA_W-1:0] reg_rd,
  input  logic [ADDR_W-1:0]             pc,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [DATA_W-1:0]             imem_rd,
  output logic [DATA_W-1:0]             instruction
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic                     accept_s, hit_s;
  logic [IDX_W-1:0]         idx_s, sel_s, sel_r;
  logic [ADDR_W-1:0]        off_s;
  logic [3:0]               cnt_r;
  logic                     we_r;
  logic [DATA_W-1:0]        data_r;
  logic [NUM_REGIONS-1:0]   reg_en_s, reg_en_r;
  logic                     reg_we_s, reg_we_r;
  logic                     resp_valid_s, resp_valid_r;
  logic                     req_ready_s, req_ready_r;
  logic [ADDR_W-1:0]        reg_addr_r;
  logic [DATA_W-1:0]        reg_wd_r, resp_rd_r, instr_r;

  // Upper bound computed one bit wider so BASE+SIZE cannot wrap.
  function automatic logic in_region(input logic [ADDR_W-1:0] a, input int i);
    logic [ADDR_W:0] base;
    logic [ADDR_W:0] lim;
    base = {1'b0, REGION_BASE[i*ADDR_W +: ADDR_W]};
    lim  = base + {1'b0, REGION_SIZE[i*ADDR_W +: ADDR_W]};
    return (REGION_SIZE[i*ADDR_W +: ADDR_W] != '0) && ({1'b0, a} >= base) && ({1'b0, a} < lim);
  endfunction

  assign accept_s = req_valid && (state_r == IDLE);

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    hit_s = 1'b0;
    idx_s = '0;
    off_s = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (in_region(req_addr, i)) begin
        hit_s = 1'b1;
        idx_s = IDX_W'(i);
        off_s = req_addr - REGION_BASE[i*ADDR_W +: ADDR_W];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = hit_s ? ACCESS : RESP;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_s = RESP;
        end else begin
          state_s = ACCESS;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode, computed one cycle ahead so the outputs leave flops.
  always_comb begin
    sel_s        = (state_r == IDLE) ? idx_s : sel_r;
    reg_en_s     = '0;
    if (state_s == ACCESS) begin
      reg_en_s = NUM_REGIONS'(1'b1) << sel_s;
    end else begin
      reg_en_s = '0;
    end
    reg_we_s     = accept_s && hit_s && req_we && !REGION_RO[idx_s];
    resp_valid_s = (state_r == RESP);
    req_ready_s  = (state_s == IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_en_r     <= '0;
      reg_we_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      req_ready_r  <= 1'b1;
    end else begin
      reg_en_r     <= reg_en_s;
      reg_we_r     <= reg_we_s;
      resp_valid_r <= resp_valid_s;
      req_ready_r  <= req_ready_s;
    end
  end

  // Transaction datapath: latch request, count wait states, capture and publish read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r      <= '0;
      we_r       <= 1'b0;
      cnt_r      <= 4'd0;
      data_r     <= '0;
      reg_addr_r <= '0;
      reg_wd_r   <= '0;
      resp_rd_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sel_r  <= idx_s;
            we_r   <= req_we;
            data_r <= '0;
            cnt_r  <= hit_s ? REGION_WS[32'(idx_s) * 32'd4 +: 4] : 4'd0;
            if (hit_s) begin
              reg_addr_r <= off_s;
              reg_wd_r   <= req_wd;
            end
          end
        end
        ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            data_r <= we_r ? '0 : reg_rd[32'(sel_r) * DATA_W +: DATA_W];
          end
        end
        RESP:    resp_rd_r <= data_r;
        default: resp_rd_r <= resp_rd_r;
      endcase
    end
  end

`ifdef MEM_MAP_CTRL_ACCESS_ERR_EN
  logic err_r, resp_err_r;

  // Error classification latched at accept, reported alongside resp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r      <= 1'b0;
      resp_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        err_r <= !hit_s || (req_we && REGION_RO[idx_s]);
      end
      resp_err_r <= (state_r == RESP) ? err_r : 1'b0;
    end
  end

  assign resp_err = resp_err_r;
`else
  assign resp_err = 1'b0;
`endif

  // Instruction fetch register, free-running beside the data FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= '0;
    end else begin
      instr_r <= (pc < IMEM_SIZE) ? imem_rd : '0;
    end
  end

  assign imem_addr   = pc;
  assign instruction = instr_r;
  assign req_ready   = req_ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_rd     = resp_rd_r;
  assign reg_en      = reg_en_r;
  assign reg_we      = reg_we_r;
  assign reg_addr    = reg_addr_r;
  assign reg_wd      = reg_wd_r;

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Directed self-checking bench for mem_map_ctrl using the default region map.
module tb_mem_map_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_we;
  logic [31:0]  req_addr, req_wd;
  logic         resp_valid, resp_err;
  logic [31:0]  resp_rd;
  logic [3:0]   reg_en;
  logic         reg_we;
  logic [31:0]  reg_addr, reg_wd;
  logic [127:0] reg_rd;
  logic [31:0]  pc, imem_addr, imem_rd, instruction;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef MEM_MAP_CTRL_ACCESS_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_map_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err),
    .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wd(reg_wd),
    .reg_rd(reg_rd), .pc(pc), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .instruction(instruction)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; checks ACCESS outputs, latency, response, and write strobe count.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input int exp_lat, input logic [3:0] exp_en,
                        input logic [31:0] exp_off, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_we);
    int lat;
    int we_cnt;
    chk({tag, " ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wd = 32'd0;
    chk({tag, " ready_busy"}, {31'd0, req_ready}, 32'd0);
    chk({tag, " reg_en"}, {28'd0, reg_en}, {28'd0, exp_en});
    if (exp_en != 4'd0) begin
      chk({tag, " reg_addr"}, reg_addr, exp_off);
      chk({tag, " reg_wd"}, reg_wd, wd);
    end
    we_cnt = int'(reg_we);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      we_cnt += int'(reg_we);
    end while (!resp_valid && lat < 20);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " resp_rd"}, resp_rd, exp_rd);
    chk({tag, " resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    chk({tag, " reg_en_off"}, {28'd0, reg_en}, 32'd0);
    chk({tag, " we_pulses"}, we_cnt, exp_we);
    @(negedge clk);
    chk({tag, " valid_drop"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " rd_hold"}, resp_rd, exp_rd);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wd = 32'd0;
    reg_rd = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h000000A5};
    pc = 32'd0; imem_rd = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst reg_en", {28'd0, reg_en}, 32'd0);
    chk("rst reg_we", {31'd0, reg_we}, 32'd0);
    chk("rst resp_rd", resp_rd, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst reg_addr", reg_addr, 32'd0);
    chk("rst instruction", instruction, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel ready", {31'd0, req_ready}, 32'd1);

    do_req("rd400",    1'b0, 32'd400,    32'd0,      2, 4'b0001, 32'd0,      32'h000000A5, 1'b0,    0);
    do_req("wr8900",   1'b1, 32'd8900,   32'h1234,   3, 4'b0100, 32'd0,      32'd0,        1'b0,    1);
    do_req("rd8499",   1'b0, 32'd8499,   32'd0,      2, 4'b0001, 32'd8099,   32'h000000A5, 1'b0,    0);
    do_req("rd8800",   1'b0, 32'd8800,   32'd0,      1, 4'b0000, 32'd0,      32'd0,        ERR_EXP, 0);
    do_req("wr8500",   1'b1, 32'd8500,   32'h55,     2, 4'b0010, 32'd0,      32'd0,        ERR_EXP, 0);
    do_req("rd8799",   1'b0, 32'd8799,   32'd0,      2, 4'b0010, 32'd299,    32'h0000BBBB, 1'b0,    0);
    do_req("rd399",    1'b0, 32'd399,    32'd0,      1, 4'b0000, 32'd0,      32'd0,        ERR_EXP, 0);
    do_req("rd138099", 1'b0, 32'd138099, 32'd0,      3, 4'b0100, 32'd129199, 32'h0000CCCC, 1'b0,    0);
    do_req("rd138100", 1'b0, 32'd138100, 32'd0,      1, 4'b0000, 32'd0,      32'd0,        ERR_EXP, 0);
    do_req("wr400",    1'b1, 32'd400,    32'h77,     2, 4'b0001, 32'd0,      32'd0,        ERR_EXP, 0);

    pc = 32'd5; imem_rd = 32'hDEAD0005;
    #1 chk("imem_addr", imem_addr, 32'd5);
    @(negedge clk);
    chk("instr pc5", instruction, 32'hDEAD0005);
    pc = 32'd400; imem_rd = 32'hBEEF0190;
    @(negedge clk);
    chk("instr pc400", instruction, 32'd0);
    pc = 32'd398; imem_rd = 32'h0000018E;
    @(negedge clk);
    chk("instr pc398", instruction, 32'h0000018E);
    pc = 32'd399; imem_rd = 32'h0000018F;
    @(negedge clk);
    chk("instr pc399", instruction, 32'd0);

    pc = 32'd5; imem_rd = 32'h0000CAFE;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd8900;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'd0;
    chk("mid reg_en", {28'd0, reg_en}, 32'd4);
    chk("mid instr", instruction, 32'h0000CAFE);
    rst_n = 1'b0;
    #1;
    chk("mid rst reg_en", {28'd0, reg_en}, 32'd0);
    chk("mid rst valid", {31'd0, resp_valid}, 32'd0);
    chk("mid rst reg_addr", reg_addr, 32'd0);
    chk("mid rst instr", instruction, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid rel ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(resp_valid) + int'(reg_we) + ((reg_en != 4'd0) ? 1 : 0);
    end
    chk("mid no activity", seen, 32'd0);

    do_req("post rd400", 1'b0, 32'd400, 32'd0, 2, 4'b0001, 32'd0, 32'h000000A5, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
